// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI (mode 0) slave that exposes NUM_REGS registers of DATA_W bits.
// Frame layout, MSB first: R/W (1 = write), ADDR_W address bits, DATA_W data bits.
// All SPI inputs are synchronised into clk. Edges are detected only on the
// synchronised copies.
// Optional read-back is enabled by defining SPI_REG_BANK_READ_EN. Without it,
// cipo and cipo_oe are tied low.
module spi_reg_bank #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Synchroniser stages: [0] and [1] form the 2-FF chain. [2] is the delayed
    // copy that the edge detectors use.
    logic [2:0] ncs_sync_reg;
    logic [2:0] sclk_sync_reg;
    logic [1:0] copi_sync_reg;

    logic ncs_fall;
    logic ncs_rise;
    logic sclk_rise;
    logic copi_s;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [FRAME-1:0]     shreg_reg, shreg_next;
    logic                 commit_reg, commit_next;

    logic [DATA_W-1:0]    regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]  wr_hit;
    logic                 frame_rw;
    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;
    logic                 addr_valid;
    logic                 do_write;
    logic                 wr_strobe_reg;
    logic [ADDR_W-1:0]    wr_addr_reg;

    // Bring the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_reg  <= '0;
            sclk_sync_reg <= '0;
            copi_sync_reg <= '0;
        end else begin
            ncs_sync_reg  <= {ncs_sync_reg[1:0], nCS};
            sclk_sync_reg <= {sclk_sync_reg[1:0], SCLK};
            copi_sync_reg <= {copi_sync_reg[0], copi};
        end
    end

    assign ncs_fall  =  ncs_sync_reg[2]  & ~ncs_sync_reg[1];
    assign ncs_rise  = ~ncs_sync_reg[2]  &  ncs_sync_reg[1];
    assign sclk_rise = ~sclk_sync_reg[2] &  sclk_sync_reg[1];
    assign copi_s    =  copi_sync_reg[1];

    // Frame FSM state, bit counter, shift register and one-cycle commit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shreg_reg  <= '0;
            commit_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            shreg_reg  <= shreg_next;
            commit_reg <= commit_next;
        end
    end

    // Next-state logic. A rise on nCS returns to IDLE from any state.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        shreg_next  = shreg_reg;
        commit_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ncs_fall) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    shreg_next = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_next = {shreg_reg[FRAME-2:0], copi_s};
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        state_next  = DONE;
                        commit_next = 1'b1;
                    end
                end
            end
            DONE: begin
                // Surplus SCLK edges are ignored until nCS goes high.
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (ncs_rise) begin
            state_next = IDLE;
        end
    end

    assign frame_rw   = shreg_reg[FRAME-1];
    assign frame_addr = shreg_reg[FRAME-2 -: ADDR_W];
    assign frame_data = shreg_reg[DATA_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_hit[gi] = (frame_addr == ADDR_W'(gi));
            assign regs_flat[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

    // The address is valid exactly when it matches an implemented register.
    assign addr_valid = |wr_hit;
    assign do_write   = commit_reg & frame_rw & addr_valid;

    // Register file. The write lands one clk after the frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_reg[k] <= '0;
            end
        end else if (do_write) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_hit[k]) begin
                    regs_reg[k] <= frame_data;
                end
            end
        end
    end

    // Write notification. The strobe goes high in the same cycle the register updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
        end else begin
            wr_strobe_reg <= do_write;
            if (do_write) begin
                wr_addr_reg <= frame_addr;
            end
        end
    end

    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;

`ifdef SPI_REG_BANK_READ_EN
    localparam int TX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] ADDR_END_CNT = CNT_W'(ADDR_W);

    logic                 sclk_fall;
    logic                 rd_rw;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_latch;
    logic [DATA_W-1:0]    rd_data;
    logic [DATA_W-1:0]    tx_shift_reg;
    logic [TX_W-1:0]      tx_left_reg;
    logic                 cipo_reg;
    logic                 cipo_oe_reg;

    assign sclk_fall = sclk_sync_reg[2] & ~sclk_sync_reg[1];

    // The R/W bit and the address sit in the low bits of shreg_next on the rise
    // that completes the address field.
    assign rd_rw    = shreg_next[ADDR_W];
    assign rd_addr  = shreg_next[ADDR_W-1:0];
    assign rd_latch = (state_reg == SHIFT) && sclk_rise && (cnt_reg == ADDR_END_CNT)
                      && !rd_rw && !ncs_rise;

    // Read mux. An address with no register reads back as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
                rd_data = regs_reg[k];
            end
        end
    end

    // Read data shifter. Each detected SCLK fall presents the next bit, MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_reg <= '0;
            tx_left_reg  <= '0;
            cipo_reg     <= 1'b0;
            cipo_oe_reg  <= 1'b0;
        end else if (ncs_rise || state_reg == IDLE) begin
            tx_shift_reg <= '0;
            tx_left_reg  <= '0;
            cipo_reg     <= 1'b0;
            cipo_oe_reg  <= 1'b0;
        end else if (rd_latch) begin
            tx_shift_reg <= rd_data;
            tx_left_reg  <= TX_W'(DATA_W);
        end else if (sclk_fall && tx_left_reg != '0) begin
            cipo_reg     <= tx_shift_reg[DATA_W-1];
            cipo_oe_reg  <= 1'b1;
            tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
            tx_left_reg  <= tx_left_reg - TX_W'(1);
        end else if (sclk_fall) begin
            cipo_reg     <= 1'b0;
            cipo_oe_reg  <= 1'b0;
        end
    end

    // Gate with synchronised nCS so that the pin is released immediately on deselect.
    assign cipo    = cipo_reg    & ~ncs_sync_reg[1];
    assign cipo_oe = cipo_oe_reg & ~ncs_sync_reg[1];
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule
